burst_req: RTL and testbench

- Requester-side front end for one port of the two-way request/grant arbiter. One instance feeds req_0/gnt_0 and a second feeds req_1/gnt_1.
- Buffers incoming words in a small FIFO and raises req while data is pending.
- Drains at most BURST_MAX words per grant, then drops req and backs off. The arbiter holds a grant for as long as req stays high, so this back-off is what makes it fair.

---
 rtl/burst_req.sv | 146 ++++++++++++++
 tb/tb_burst_req.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_req.sv
// Requester front end for one arbiter port: buffers words in a small FIFO,
// requests while data is pending and drains at most BURST_MAX words per grant.
module burst_req #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int BURST_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              req,
    input  logic              gnt,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BEAT_W = $clog2(BURST_MAX + 1);

    // Bit 0 of the encoding is the request line, so req comes straight off a flop.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        XFER    = 2'b11,
        BACKOFF = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    count_nxt_s;
    logic [BEAT_W-1:0]   beats_r;
    logic [BEAT_W-1:0]   beats_inc_s;
    logic                push_s;
    logic                pop_s;
    logic [DATA_W-1:0]   out_data_r;
    logic                out_valid_r;

    // FIFO handshake and occupancy arithmetic
    always_comb begin
        in_ready    = (count_r != CNT_W'(DEPTH));
        push_s      = in_valid && in_ready;
        pop_s       = (state_r == XFER) && gnt && (count_r != {CNT_W{1'b0}});
        count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        beats_inc_s = beats_r + BEAT_W'(1);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (count_r != {CNT_W{1'b0}}) state_nxt_s = REQ;
                else                          state_nxt_s = IDLE;
            end
            REQ: begin
                if (gnt) state_nxt_s = XFER;
                else     state_nxt_s = REQ;
            end
            XFER: begin
                if (!gnt) begin
                    state_nxt_s = REQ;
                end else if (pop_s && ((beats_inc_s == BEAT_W'(BURST_MAX)) ||
                                       (count_nxt_s == {CNT_W{1'b0}}))) begin
                    state_nxt_s = BACKOFF;
                end else begin
                    state_nxt_s = XFER;
                end
            end
            BACKOFF: begin
                if (!gnt) state_nxt_s = IDLE;
                else      state_nxt_s = BACKOFF;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode from the state flop
    always_comb begin
        req       = state_r[0];
        out_data  = out_data_r;
        out_valid = out_valid_r;
    end

    // FIFO storage; contents are don't-care until the count covers them
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and count
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            count_r <= count_nxt_s;
        end
    end

    // Per-grant beat counter, restarted whenever a grant is (re)acquired
    always_ff @(posedge clock) begin
        if (reset) begin
            beats_r <= {BEAT_W{1'b0}};
        end else if ((state_r == REQ) && gnt) begin
            beats_r <= {BEAT_W{1'b0}};
        end else if (pop_s) begin
            beats_r <= beats_inc_s;
        end else begin
            beats_r <= beats_r;
        end
    end

    // Registered pop outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else begin
            out_valid_r <= pop_s;
            if (pop_s) out_data_r <= mem_r[rd_ptr_r];
        end
    end

endmodule

// File: tb/tb_burst_req.sv
// Self-checking bench for burst_req: a queue-based reference model predicts
// every output each cycle; directed scenarios pin latency and ordering.
module tb_burst_req;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 4;
    localparam int BURST_MAX = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              req;
    logic              gnt;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;

    burst_req #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BURST_MAX(BURST_MAX)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .req      (req),
        .gnt      (gnt),
        .out_data (out_data),
        .out_valid(out_valid)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // reference model: word queue plus the requester's phase in the burst protocol
    logic [DATA_W-1:0] mq[$];
    int                ph;        // 0 idle, 1 requesting, 2 transferring, 3 backing off
    int                beats;
    bit                m_req;
    bit                m_ov;
    logic [DATA_W-1:0] m_od;

    // observation bookkeeping
    logic [DATA_W-1:0] cap[$];
    int                cap_cyc[$];
    int                cyc = 0;
    bit                rq_hist0 = 1'b0;
    bit                rq_hist1 = 1'b0;
    int                gmode = 0;  // 0 direct, 1 two-cycle lag, 2 lag with drops, 3 forced
    bit                gforce = 1'b0;
    int                low_run = 0;
    bit                seen_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input bit rst, input bit v, input logic [DATA_W-1:0] d, input bit g);
        bit pushed;
        bit popped;
        int n;
        if (rst) begin
            mq.delete();
            ph    = 0;
            beats = 0;
            m_ov  = 1'b0;
            m_od  = '0;
        end else begin
            pushed = v && (mq.size() < DEPTH);
            popped = (ph == 2) && g && (mq.size() > 0);
            m_ov   = popped;
            if (popped) m_od = mq[0];
            n = mq.size() + int'(pushed) - int'(popped);
            case (ph)
                0: if (mq.size() != 0) ph = 1;
                1: if (g) begin ph = 2; beats = 0; end
                2: begin
                    if (!g) ph = 1;
                    else if (popped) begin
                        beats++;
                        if (beats == BURST_MAX || n == 0) ph = 3;
                    end
                end
                3: if (!g) ph = 0;
                default: ph = 0;
            endcase
            if (popped) void'(mq.pop_front());
            if (pushed) mq.push_back(d);
        end
        m_req = (ph == 1) || (ph == 2);
    endtask

    // one clock: drive at negedge, advance model, compare at the next negedge
    task automatic step(input bit rst, input bit v, input logic [DATA_W-1:0] d);
        bit g;
        case (gmode)
            0:       g = req;
            1:       g = rq_hist1;
            2:       g = rq_hist1 && ($urandom_range(0, 9) != 0);
            default: g = gforce;
        endcase
        rq_hist1 = rq_hist0;
        rq_hist0 = req;
        reset    = rst;
        in_valid = v;
        in_data  = d;
        gnt      = g;
        model_step(rst, v, d, g);
        @(negedge clock);
        cyc++;
        chk("req", 32'(req), 32'(m_req));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        if (out_valid === 1'b1) begin
            cap.push_back(out_data);
            cap_cyc.push_back(cyc);
        end
        if (rst) begin
            seen_req = 1'b0;
            low_run  = 0;
        end else if (req === 1'b1) begin
            if (seen_req && low_run > 0) chk("req_low_gap", 32'(low_run >= 2), 32'd1);
            seen_req = 1'b1;
            low_run  = 0;
        end else begin
            low_run++;
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        cap.delete();
        cap_cyc.delete();
    endtask

    initial begin
        int start;
        int idx;
        int guard;
        logic [DATA_W-1:0] w;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        gnt      = 1'b0;
        @(negedge clock);

        // reset state
        do_reset();
        step(1'b0, 1'b0, 8'h00);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);

        // two words, grant follows req directly
        gmode = 0;
        step(1'b0, 1'b1, 8'hA1);
        start = cyc;
        step(1'b0, 1'b1, 8'hA2);
        repeat (12) step(1'b0, 1'b0, 8'h00);
        chk("two_count", 32'(cap.size()), 32'd2);
        if (cap.size() == 2) begin
            chk("two_w0", 32'(cap[0]), 32'hA1);
            chk("two_w1", 32'(cap[1]), 32'hA2);
            chk("two_lat", 32'(cap_cyc[0] - start), 32'd3);
            chk("two_consec", 32'(cap_cyc[1] - cap_cyc[0]), 32'd1);
        end
        chk("two_idle_req", 32'(req), 32'd0);

        // latency through a two-cycle grant lag
        do_reset();
        gmode = 1;
        step(1'b0, 1'b1, 8'h55);
        start = cyc;
        repeat (12) step(1'b0, 1'b0, 8'h00);
        chk("lag_count", 32'(cap.size()), 32'd1);
        if (cap.size() == 1) begin
            chk("lag_word", 32'(cap[0]), 32'h55);
            chk("lag_lat", 32'(cap_cyc[0] - start), 32'd5);
        end

        // eight words through a four-deep FIFO: two bursts of four
        do_reset();
        gmode = 0;
        idx   = 0;
        guard = 0;
        while (idx < 8 && guard < 200) begin
            w = 8'h10 + 8'(idx);
            if (in_ready === 1'b1) begin
                step(1'b0, 1'b1, w);
                idx++;
            end else begin
                step(1'b0, 1'b1, w);
            end
            guard++;
        end
        chk("fill_pushed", 32'(idx), 32'd8);
        repeat (25) step(1'b0, 1'b0, 8'h00);
        chk("fill_count", 32'(cap.size()), 32'd8);
        if (cap.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("fill_word", 32'(cap[i]), 32'h10 + 32'(i));
            chk("fill_burst1", 32'(cap_cyc[3] - cap_cyc[0]), 32'd3);
            chk("fill_gap", 32'(cap_cyc[4] - cap_cyc[3]), 32'd4);
            chk("fill_burst2", 32'(cap_cyc[7] - cap_cyc[4]), 32'd3);
        end

        // grant dropped for one cycle after the first pop
        do_reset();
        gmode = 0;
        step(1'b0, 1'b1, 8'hC1);
        step(1'b0, 1'b1, 8'hC2);
        step(1'b0, 1'b1, 8'hC3);
        guard = 0;
        while (cap.size() == 0 && guard < 20) begin
            step(1'b0, 1'b0, 8'h00);
            guard++;
        end
        chk("drop_first_seen", 32'(cap.size()), 32'd1);
        gmode  = 3;
        gforce = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        chk("drop_no_pop", 32'(out_valid), 32'd0);
        gmode = 0;
        repeat (15) step(1'b0, 1'b0, 8'h00);
        chk("drop_count", 32'(cap.size()), 32'd3);
        if (cap.size() == 3) begin
            chk("drop_w1", 32'(cap[1]), 32'hC2);
            chk("drop_w2", 32'(cap[2]), 32'hC3);
        end

        // reset while in transfer with three words buffered
        do_reset();
        gmode  = 3;
        gforce = 1'b0;
        step(1'b0, 1'b1, 8'hD1);
        step(1'b0, 1'b1, 8'hD2);
        step(1'b0, 1'b1, 8'hD3);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        gforce = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        gforce = 1'b0;
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("mid_rst_req", 32'(req), 32'd0);
        chk("mid_rst_ov", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        gmode = 0;
        repeat (10) step(1'b0, 1'b0, 8'h00);
        chk("mid_rst_no_out", 32'(cap.size()), 32'd0);

        // randomized traffic with lagging, occasionally dropped grants
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) gmode = $urandom_range(0, 2);
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 1) == 1), 8'($urandom));
        end
        gmode = 1;
        repeat (40) step(1'b0, 1'b0, 8'h00);
        chk("rand_drained", 32'(mq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
